axi4_lite_master: RTL and testbench



---
 rtl/axi4_lite_pkg.sv | 9 +
 rtl/axi4_lite_master_rd.sv | 59 +++++
 rtl/axi4_lite_master.sv | 112 +++++++++++
 tb/tb_axi4_lite_master.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/axi4_lite_pkg.sv
// axi4_lite_pkg: shared response codes, protection default and FSM state encodings for the AXI4-Lite master
package axi4_lite_pkg;
  localparam logic [1:0] RESP_OKAY   = 2'd0;
  localparam logic [1:0] RESP_SLVERR = 2'd2;
  localparam logic [1:0] RESP_DECERR = 2'd3;
  localparam logic [2:0] PROT_DEFAULT = 3'b000;
  typedef enum logic [1:0] {W_IDLE, W_ADDR_DATA, W_RESP} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} r_state_t;
endpackage

// File: rtl/axi4_lite_master_rd.sv
// axi4_lite_master_rd: read FSM turning an amci_read strobe into one AR/R transaction (amci_* command side, ar*/r* AXI side)
module axi4_lite_master_rd
  import axi4_lite_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic [AW-1:0] amci_raddr,
  input  logic          amci_read,
  output logic [DW-1:0] amci_rdata,
  output logic [1:0]    amci_rresp,
  output logic          amci_rdone,
  output logic          amci_ridle,
  output logic [AW-1:0] araddr,
  output logic          arvalid,
  input  logic          arready,
  input  logic [DW-1:0] rdata,
  input  logic [1:0]    rresp,
  input  logic          rvalid,
  output logic          rready
);
  r_state_t state;
  assign amci_ridle = (state == R_IDLE) && !amci_read;
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= R_IDLE;
      araddr     <= '0;
      arvalid    <= 1'b0;
      rready     <= 1'b0;
      amci_rdata <= '0;
      amci_rresp <= RESP_OKAY;
      amci_rdone <= 1'b0;
    end else begin
      amci_rdone <= 1'b0;
      case (state)
        R_IDLE: if (amci_read) begin
          araddr  <= amci_raddr;
          arvalid <= 1'b1;
          rready  <= 1'b1;
          state   <= R_ADDR;
        end
        R_ADDR: if (arready) begin
          arvalid <= 1'b0;
          state   <= R_DATA;
        end
        R_DATA: if (rvalid) begin
          amci_rdata <= rdata;
          amci_rresp <= rresp;
          rready     <= 1'b0;
          amci_rdone <= 1'b1;
          state      <= R_IDLE;
        end
        default: state <= R_IDLE;
      endcase
    end
  end
endmodule

// File: rtl/axi4_lite_master.sv
// axi4_lite_master: AMCI strobe interface to AXI4-Lite initiator; write FSM here, read FSM in axi4_lite_master_rd
module axi4_lite_master
  import axi4_lite_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic [AW-1:0]   amci_waddr,
  input  logic [DW-1:0]   amci_wdata,
  input  logic            amci_write,
  output logic [1:0]      amci_wresp,
  output logic            amci_wdone,
  output logic            amci_widle,
  input  logic [AW-1:0]   amci_raddr,
  input  logic            amci_read,
  output logic [DW-1:0]   amci_rdata,
  output logic [1:0]      amci_rresp,
  output logic            amci_rdone,
  output logic            amci_ridle,
  output logic [AW-1:0]   M_AXI_AWADDR,
  output logic            M_AXI_AWVALID,
  input  logic            M_AXI_AWREADY,
  output logic [2:0]      M_AXI_AWPROT,
  output logic [DW-1:0]   M_AXI_WDATA,
  output logic [DW/8-1:0] M_AXI_WSTRB,
  output logic            M_AXI_WVALID,
  input  logic            M_AXI_WREADY,
  input  logic [1:0]      M_AXI_BRESP,
  input  logic            M_AXI_BVALID,
  output logic            M_AXI_BREADY,
  output logic [AW-1:0]   M_AXI_ARADDR,
  output logic            M_AXI_ARVALID,
  input  logic            M_AXI_ARREADY,
  output logic [2:0]      M_AXI_ARPROT,
  input  logic [DW-1:0]   M_AXI_RDATA,
  input  logic [1:0]      M_AXI_RRESP,
  input  logic            M_AXI_RVALID,
  output logic            M_AXI_RREADY
);
  w_state_t state;
  logic aw_pend, w_pend;
  // a channel is still outstanding after this edge only if it is valid and not accepted now
  assign aw_pend = M_AXI_AWVALID && !M_AXI_AWREADY;
  assign w_pend = M_AXI_WVALID && !M_AXI_WREADY;
  assign amci_widle = (state == W_IDLE) && !amci_write;
  assign M_AXI_AWPROT = PROT_DEFAULT;
  assign M_AXI_ARPROT = PROT_DEFAULT;
  assign M_AXI_WSTRB = {(DW/8){M_AXI_WVALID}};
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state         <= W_IDLE;
      M_AXI_AWADDR  <= '0;
      M_AXI_AWVALID <= 1'b0;
      M_AXI_WDATA   <= '0;
      M_AXI_WVALID  <= 1'b0;
      M_AXI_BREADY  <= 1'b0;
      amci_wresp    <= RESP_OKAY;
      amci_wdone    <= 1'b0;
    end else begin
      amci_wdone <= 1'b0;
      case (state)
        W_IDLE: if (amci_write) begin
          M_AXI_AWADDR  <= amci_waddr;
          M_AXI_WDATA   <= amci_wdata;
          M_AXI_AWVALID <= 1'b1;
          M_AXI_WVALID  <= 1'b1;
          M_AXI_BREADY  <= 1'b1;
          state         <= W_ADDR_DATA;
        end
        W_ADDR_DATA: begin
          if (M_AXI_AWREADY) M_AXI_AWVALID <= 1'b0;
          if (M_AXI_WREADY) M_AXI_WVALID <= 1'b0;
          // BREADY is already high, so a B arriving on the final handshake edge completes here
          if (!aw_pend && !w_pend) begin
            if (M_AXI_BVALID) begin
              amci_wresp   <= M_AXI_BRESP;
              M_AXI_BREADY <= 1'b0;
              amci_wdone   <= 1'b1;
              state        <= W_IDLE;
            end else state <= W_RESP;
          end
        end
        W_RESP: if (M_AXI_BVALID) begin
          amci_wresp   <= M_AXI_BRESP;
          M_AXI_BREADY <= 1'b0;
          amci_wdone   <= 1'b1;
          state        <= W_IDLE;
        end
        default: state <= W_IDLE;
      endcase
    end
  end
  axi4_lite_master_rd #(.AW(AW), .DW(DW)) u_rd (
    .clk        (clk),
    .resetn     (resetn),
    .amci_raddr (amci_raddr),
    .amci_read  (amci_read),
    .amci_rdata (amci_rdata),
    .amci_rresp (amci_rresp),
    .amci_rdone (amci_rdone),
    .amci_ridle (amci_ridle),
    .araddr     (M_AXI_ARADDR),
    .arvalid    (M_AXI_ARVALID),
    .arready    (M_AXI_ARREADY),
    .rdata      (M_AXI_RDATA),
    .rresp      (M_AXI_RRESP),
    .rvalid     (M_AXI_RVALID),
    .rready     (M_AXI_RREADY)
  );
endmodule

// File: tb/tb_axi4_lite_master.sv
// tb_axi4_lite_master: directed checks of axi4_lite_master against a small register-file AXI4-Lite slave
module tb_axi4_lite_master;
  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [31:0] amci_waddr = '0, amci_wdata = '0, amci_raddr = '0;
  logic        amci_write = 1'b0, amci_read = 1'b0;
  logic [1:0]  amci_wresp, amci_rresp;
  logic        amci_wdone, amci_widle, amci_rdone, amci_ridle;
  logic [31:0] amci_rdata;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [2:0]  awprot, arprot;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;
  int n_asrt = 0, n_fail = 0;
  always #5 clk = ~clk;

  axi4_lite_master dut (
    .clk(clk), .resetn(resetn),
    .amci_waddr(amci_waddr), .amci_wdata(amci_wdata), .amci_write(amci_write),
    .amci_wresp(amci_wresp), .amci_wdone(amci_wdone), .amci_widle(amci_widle),
    .amci_raddr(amci_raddr), .amci_read(amci_read), .amci_rdata(amci_rdata),
    .amci_rresp(amci_rresp), .amci_rdone(amci_rdone), .amci_ridle(amci_ridle),
    .M_AXI_AWADDR(awaddr), .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready), .M_AXI_AWPROT(awprot),
    .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready),
    .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready),
    .M_AXI_ARADDR(araddr), .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready), .M_AXI_ARPROT(arprot),
    .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready)
  );

  // slave: 16 registers at 0x00-0x3C, DECERR elsewhere; readies held off for a configurable number of valid cycles
  logic [31:0] mem [16];
  logic        aw_got, w_got, ar_got;
  logic [31:0] s_awaddr, s_wdata, s_araddr;
  int          w_cnt, ar_cnt;
  int          w_delay = 0, ar_delay = 0;
  assign awready = !aw_got && !bvalid;
  assign wready  = !w_got && !bvalid && (w_cnt >= w_delay);
  assign arready = !ar_got && !rvalid && (ar_cnt >= ar_delay);

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      aw_got <= 1'b0; w_got <= 1'b0; bvalid <= 1'b0; bresp <= 2'd0; w_cnt <= 0;
      s_awaddr <= '0; s_wdata <= '0;
      for (int i = 0; i < 16; i++) mem[i] <= '0;
    end else if (bvalid) begin
      if (bready) begin bvalid <= 1'b0; aw_got <= 1'b0; w_got <= 1'b0; w_cnt <= 0; end
    end else if (aw_got && w_got) begin
      bvalid <= 1'b1;
      if (s_awaddr < 32'h40) begin mem[s_awaddr[5:2]] <= s_wdata; bresp <= 2'd0; end
      else bresp <= 2'd3;
    end else begin
      if (awvalid && awready) begin aw_got <= 1'b1; s_awaddr <= awaddr; end
      if (wvalid && wready) begin w_got <= 1'b1; s_wdata <= wdata; end
      if (wvalid && !w_got) w_cnt <= w_cnt + 1;
    end
  end

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ar_got <= 1'b0; rvalid <= 1'b0; rdata <= '0; rresp <= 2'd0; ar_cnt <= 0; s_araddr <= '0;
    end else if (rvalid) begin
      if (rready) begin rvalid <= 1'b0; ar_got <= 1'b0; ar_cnt <= 0; end
    end else if (ar_got) begin
      rvalid <= 1'b1;
      rdata  <= (s_araddr < 32'h40) ? mem[s_araddr[5:2]] : 32'h0;
      rresp  <= (s_araddr < 32'h40) ? 2'd0 : 2'd3;
    end else begin
      if (arvalid && arready) begin ar_got <= 1'b1; s_araddr <= araddr; end
      if (arvalid) ar_cnt <= ar_cnt + 1;
    end
  end

  // negedge monitor: handshake/pulse counts and WVALID/WDATA stability while stalled
  int aw_hs = 0, awv_cyc = 0, wv_cyc = 0, arv_cyc = 0, wdone_cnt = 0, rdone_cnt = 0, w_unstable = 0;
  logic        w_hold = 1'b0;
  logic [31:0] w_prev = '0;
  always @(negedge clk) begin
    if (resetn) begin
      if (awvalid && awready) aw_hs++;
      if (awvalid) awv_cyc++;
      if (wvalid) wv_cyc++;
      if (arvalid) arv_cyc++;
      if (amci_wdone) wdone_cnt++;
      if (amci_rdone) rdone_cnt++;
      if (w_hold && (!wvalid || wdata !== w_prev)) w_unstable++;
      w_hold = wvalid && !wready;
      w_prev = wdata;
    end else w_hold = 1'b0;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    aw_hs = 0; awv_cyc = 0; wv_cyc = 0; arv_cyc = 0; wdone_cnt = 0; rdone_cnt = 0; w_unstable = 0;
  endtask

  task automatic strobe_write(input logic [31:0] a, input logic [31:0] d);
    amci_waddr = a; amci_wdata = d; amci_write = 1'b1;
    #1 chk("widle_during_strobe", {31'd0, amci_widle}, 32'd0);
    @(negedge clk);
    amci_write = 1'b0;
  endtask

  task automatic strobe_read(input logic [31:0] a);
    amci_raddr = a; amci_read = 1'b1;
    #1 chk("ridle_during_strobe", {31'd0, amci_ridle}, 32'd0);
    @(negedge clk);
    amci_read = 1'b0;
  endtask

  task automatic wait_wdone(input int budget);
    int i = 0;
    while (!amci_wdone && i < budget) begin @(negedge clk); i++; end
    chk("wdone_within_budget", {31'd0, amci_wdone}, 32'd1);
  endtask

  task automatic wait_rdone(input int budget);
    int i = 0;
    while (!amci_rdone && i < budget) begin @(negedge clk); i++; end
    chk("rdone_within_budget", {31'd0, amci_rdone}, 32'd1);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_awvalid", {31'd0, awvalid}, 32'd0);
    chk("rst_wvalid", {31'd0, wvalid}, 32'd0);
    chk("rst_bready", {31'd0, bready}, 32'd0);
    chk("rst_arvalid", {31'd0, arvalid}, 32'd0);
    chk("rst_rready", {31'd0, rready}, 32'd0);
    chk("rst_awaddr", awaddr, 32'd0);
    chk("rst_wstrb", {28'd0, wstrb}, 32'd0);
    chk("rst_rdata", amci_rdata, 32'd0);
    chk("rst_idle", {30'd0, amci_widle, amci_ridle}, 32'd3);
    chk("rst_done", {30'd0, amci_wdone, amci_rdone}, 32'd0);
    resetn = 1'b1;
    @(negedge clk);

    // zero-wait write of 0x1000 to 0x04
    clr();
    strobe_write(32'h04, 32'h1000);
    chk("t1_valids", {29'd0, awvalid, wvalid, bready}, 32'd7);
    chk("t1_awaddr", awaddr, 32'h04);
    chk("t1_wdata", wdata, 32'h1000);
    chk("t1_wstrb", {28'd0, wstrb}, 32'hF);
    chk("t1_prot", {26'd0, awprot, arprot}, 32'd0);
    chk("t1_widle_busy", {31'd0, amci_widle}, 32'd0);
    @(negedge clk);
    chk("t1_valids_dropped", {30'd0, awvalid, wvalid}, 32'd0);
    chk("t1_wstrb_idle", {28'd0, wstrb}, 32'd0);
    @(negedge clk);
    chk("t1_no_early_wdone", {31'd0, amci_wdone}, 32'd0);
    @(negedge clk);
    chk("t1_wdone_strobe_plus3", {31'd0, amci_wdone}, 32'd1);
    chk("t1_wresp", {30'd0, amci_wresp}, 32'd0);
    chk("t1_widle_after", {31'd0, amci_widle}, 32'd1);
    chk("t1_bready_dropped", {31'd0, bready}, 32'd0);
    chk("t1_slave_reg", mem[1], 32'd4096);
    @(negedge clk);
    chk("t1_wdone_one_cycle", {31'd0, amci_wdone}, 32'd0);

    // WREADY held off: AWVALID one cycle, WVALID six cycles with WDATA stable
    w_delay = 5;
    clr();
    strobe_write(32'h00, 32'hA5A5_0001);
    wait_wdone(30);
    @(negedge clk);
    chk("t2_awvalid_cycles", awv_cyc, 32'd1);
    chk("t2_wvalid_cycles", wv_cyc, 32'd6);
    chk("t2_wdata_stable", w_unstable, 32'd0);
    chk("t2_wdone_count", wdone_cnt, 32'd1);
    chk("t2_slave_reg", mem[0], 32'hA5A5_0001);
    w_delay = 0;

    // read of unmapped 0x7C with ARREADY held off three cycles
    ar_delay = 3;
    clr();
    strobe_read(32'h7C);
    chk("t3_arvalid_rready", {30'd0, arvalid, rready}, 32'd3);
    chk("t3_araddr", araddr, 32'h7C);
    wait_rdone(30);
    chk("t3_rresp_decerr", {30'd0, amci_rresp}, 32'd3);
    chk("t3_rdata", amci_rdata, 32'd0);
    @(negedge clk);
    chk("t3_arvalid_cycles", arv_cyc, 32'd4);
    chk("t3_rdone_count", rdone_cnt, 32'd1);
    ar_delay = 0;

    // write and read strobed on the same edge
    clr();
    amci_waddr = 32'h00; amci_wdata = 32'h1; amci_write = 1'b1;
    amci_raddr = 32'h04; amci_read = 1'b1;
    @(negedge clk);
    amci_write = 1'b0; amci_read = 1'b0;
    repeat (8) @(negedge clk);
    chk("t4_wdone_count", wdone_cnt, 32'd1);
    chk("t4_rdone_count", rdone_cnt, 32'd1);
    chk("t4_rdata", amci_rdata, 32'h1000);
    chk("t4_resps", {28'd0, amci_wresp, amci_rresp}, 32'd0);
    chk("t4_slave_reg0", mem[0], 32'h1);
    chk("t4_both_idle", {30'd0, amci_widle, amci_ridle}, 32'd3);

    // re-strobe while the write path is busy is ignored
    clr();
    strobe_write(32'h08, 32'h55);
    chk("t5_widle_busy", {31'd0, amci_widle}, 32'd0);
    amci_waddr = 32'h0C; amci_wdata = 32'h66; amci_write = 1'b1;
    @(negedge clk);
    chk("t5_widle_busy2", {31'd0, amci_widle}, 32'd0);
    amci_write = 1'b0;
    wait_wdone(20);
    repeat (3) @(negedge clk);
    chk("t5_aw_handshakes", aw_hs, 32'd1);
    chk("t5_wdone_count", wdone_cnt, 32'd1);
    chk("t5_reg_written", mem[2], 32'h55);
    chk("t5_reg_untouched", mem[3], 32'h0);

    // asynchronous reset while WVALID is high
    w_delay = 10;
    clr();
    strobe_write(32'h10, 32'h77);
    chk("t6_wvalid_before", {31'd0, wvalid}, 32'd1);
    #2 resetn = 1'b0;
    #1 chk("t6_async_clear", {27'd0, awvalid, wvalid, bready, arvalid, rready}, 32'd0);
    chk("t6_wstrb_clear", {28'd0, wstrb}, 32'd0);
    chk("t6_widle_in_reset", {31'd0, amci_widle}, 32'd1);
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    w_delay = 0;
    @(negedge clk);
    chk("t6_widle_after", {31'd0, amci_widle}, 32'd1);
    repeat (5) @(negedge clk);
    chk("t6_no_wdone", wdone_cnt, 32'd0);
    chk("t6_still_quiet", {30'd0, awvalid, wvalid}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end
endmodule
